// File: rtl/gfx_pkg.sv
// gfx_pkg: shared state encoding, texel size and RGB565 expansion for the fragment texture stage
package gfx_pkg;
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    ADDR  = 5'b00010,
    FETCH = 5'b00100,
    OUT   = 5'b01000,
    ACK   = 5'b10000
  } frag_state_e;
  localparam int TEXEL_BPP = 16;
  function automatic logic [31:0] rgb565_to_argb(input logic [7:0] a, input logic [15:0] texel);
    return {a, texel[15:11], texel[15:13], texel[10:5], texel[10:9], texel[4:0], texel[4:2]};
  endfunction
endpackage

// File: rtl/gfx_texel_extract.sv
// gfx_texel_extract: selects one RGB565 texel from a memory word and expands it to ARGB
module gfx_texel_extract
  import gfx_pkg::*;
#(
  parameter int MDW = 256
) (
  input  logic [MDW-1:0]                     data,
  input  logic [$clog2(MDW/TEXEL_BPP)-1:0]   lane,
  input  logic [7:0]                         a,
  output logic [31:0]                        argb
);
  assign argb = rgb565_to_argb(a, data[32'(lane) * TEXEL_BPP +: TEXEL_BPP]);
endmodule

// File: rtl/gfx_fragment_tex.sv
// gfx_fragment_tex: fragment stage with clamped RGB565 texture fetch; GFX_FRAG_COLORKEY_EN builds colour-key discard
module gfx_fragment_tex
  import gfx_pkg::*;
#(
  parameter int point_width = 16,
  parameter int MDW = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   texture_enable_i,
  input  logic [31:0]            tex_base_i,
  input  logic [point_width-1:0] tex_size_x_i,
  input  logic [point_width-1:0] tex_size_y_i,
  input  logic                   colorkey_enable_i,
  input  logic [31:0]            colorkey_i,
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic [point_width-1:0] pixel_z_i,
  input  logic [point_width-1:0] u_i,
  input  logic [point_width-1:0] v_i,
  input  logic [7:0]             a_i,
  input  logic [31:0]            color_i,
  input  logic                   write_i,
  output logic                   ack_o,
  output logic                   tex_request_o,
  output logic [31:0]            tex_addr_o,
  input  logic                   tex_ack_i,
  input  logic [MDW-1:0]         tex_data_i,
  input  logic                   wbm_busy_i,
  output logic [point_width-1:0] pixel_x_o,
  output logic [point_width-1:0] pixel_y_o,
  output logic [point_width-1:0] pixel_z_o,
  output logic [7:0]             a_o,
  output logic [31:0]            color_o,
  output logic                   write_o,
  input  logic                   ack_i
);
  localparam int OB = $clog2(MDW / 8);
  frag_state_e state_q, state_d;
  logic [point_width-1:0] u_q, v_q, sx, sy, uc, vc;
  logic [OB-2:0] lane_q;
  logic [31:0] idx, byte_addr, argb;
  logic keyed, unused_ok;
  assign sx = tex_size_x_i == '0 ? point_width'(1) : tex_size_x_i;
  assign sy = tex_size_y_i == '0 ? point_width'(1) : tex_size_y_i;
  assign uc = u_q < sx ? u_q : sx - 1'b1;
  assign vc = v_q < sy ? v_q : sy - 1'b1;
  assign idx = 32'(vc) * 32'(sx) + 32'(uc);
  assign byte_addr = tex_base_i + (idx << 1);
  gfx_texel_extract #(.MDW(MDW)) u_ext (
    .data (tex_data_i),
    .lane (lane_q),
    .a    (a_o),
    .argb (argb)
  );
`ifdef GFX_FRAG_COLORKEY_EN
  assign keyed = colorkey_enable_i && ((argb ^ colorkey_i) & 32'h00FF_FFFF) == '0;
  assign unused_ok = byte_addr[0];
`else
  assign keyed = 1'b0;
  assign unused_ok = ^{byte_addr[0], colorkey_enable_i, colorkey_i};
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = write_i ? (texture_enable_i ? ADDR : OUT) : IDLE;
      ADDR:    state_d = FETCH;
      FETCH:   state_d = tex_ack_i ? (keyed ? ACK : OUT) : FETCH;
      OUT:     state_d = (write_o && ack_i) ? ACK : OUT;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      ack_o         <= 1'b0;
      tex_request_o <= 1'b0;
      tex_addr_o    <= '0;
      pixel_x_o     <= '0;
      pixel_y_o     <= '0;
      pixel_z_o     <= '0;
      a_o           <= '0;
      color_o       <= '0;
      write_o       <= 1'b0;
      u_q           <= '0;
      v_q           <= '0;
      lane_q        <= '0;
    end else begin
      state_q <= state_d;
      ack_o   <= state_d == ACK;
      if (state_q == IDLE && write_i) begin
        pixel_x_o <= pixel_x_i;
        pixel_y_o <= pixel_y_i;
        pixel_z_o <= pixel_z_i;
        a_o       <= a_i;
        u_q       <= u_i;
        v_q       <= v_i;
        if (!texture_enable_i) color_o <= color_i;
      end
      if (state_q == ADDR) begin
        tex_addr_o <= byte_addr & ~(32'(MDW / 8) - 32'd1);
        lane_q     <= byte_addr[OB-1:1];
      end
      if (state_q == FETCH) begin
        tex_request_o <= tex_ack_i ? 1'b0 : (tex_request_o | ~wbm_busy_i);
        if (tex_ack_i && !keyed) color_o <= argb;
      end
      if (state_q == OUT) write_o <= ~(write_o & ack_i);
    end
  end
endmodule

// File: tb/tb_gfx_fragment_tex.sv
// tb_gfx_fragment_tex: table-driven and randomized checks of gfx_fragment_tex against an arithmetic reference model
module tb_gfx_fragment_tex;
  localparam int PW = 16;
  localparam int MDW = 256;
`ifdef GFX_FRAG_COLORKEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif
  typedef struct packed {
    logic te; logic [31:0] base; logic [15:0] sx; logic [15:0] sy; logic [15:0] u; logic [15:0] v;
    logic [15:0] x; logic [15:0] y; logic [15:0] z; logic [7:0] a; logic [31:0] color; logic cke; logic [31:0] key;
  } pix_t;
  typedef struct packed {
    pix_t p; logic [31:0] f_addr; logic [15:0] f_val; logic [31:0] e_addr; logic [31:0] e_color; logic e_write;
  } vec_t;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic texture_enable_i = 0, colorkey_enable_i = 0, write_i = 0, tex_ack_i = 0, wbm_busy_i = 0, ack_i = 0;
  logic [31:0] tex_base_i = 0, colorkey_i = 0, color_i = 0;
  logic [PW-1:0] tex_size_x_i = 0, tex_size_y_i = 0, pixel_x_i = 0, pixel_y_i = 0, pixel_z_i = 0, u_i = 0, v_i = 0;
  logic [7:0] a_i = 0;
  logic [MDW-1:0] tex_data_i = '0;
  logic ack_o, tex_request_o, write_o;
  logic [31:0] tex_addr_o, color_o;
  logic [PW-1:0] pixel_x_o, pixel_y_o, pixel_z_o;
  logic [7:0] a_o;
  int checks = 0, errors = 0;
  logic force_en = 0;
  logic [31:0] force_addr = 0;
  logic [15:0] force_val = 0;
  vec_t tbl[8];
  always #5 clk_i = ~clk_i;
  gfx_fragment_tex #(.point_width(PW), .MDW(MDW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .texture_enable_i(texture_enable_i), .tex_base_i(tex_base_i),
    .tex_size_x_i(tex_size_x_i), .tex_size_y_i(tex_size_y_i), .colorkey_enable_i(colorkey_enable_i),
    .colorkey_i(colorkey_i), .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i), .pixel_z_i(pixel_z_i),
    .u_i(u_i), .v_i(v_i), .a_i(a_i), .color_i(color_i), .write_i(write_i), .ack_o(ack_o),
    .tex_request_o(tex_request_o), .tex_addr_o(tex_addr_o), .tex_ack_i(tex_ack_i), .tex_data_i(tex_data_i),
    .wbm_busy_i(wbm_busy_i), .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .pixel_z_o(pixel_z_o),
    .a_o(a_o), .color_o(color_o), .write_o(write_o), .ack_i(ack_i)
  );
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [15:0] mem16(input logic [31:0] addr);
    logic [31:0] h;
    h = addr * 32'h9E37_79B1;
    return (force_en && addr == force_addr) ? force_val : (h[28:13] ^ addr[15:0]);
  endfunction
  function automatic logic [31:0] m_byte(input pix_t p);
    int unsigned sx, sy, uc, vc;
    sx = (p.sx == 0) ? 1 : 32'(p.sx);
    sy = (p.sy == 0) ? 1 : 32'(p.sy);
    uc = (32'(p.u) < sx) ? 32'(p.u) : sx - 1;
    vc = (32'(p.v) < sy) ? 32'(p.v) : sy - 1;
    return p.base + (vc * sx + uc) * 2;
  endfunction
  function automatic logic [31:0] m_argb(input logic [7:0] a, input logic [15:0] t);
    int unsigned r, g, b;
    r = 32'(t[15:11]);
    g = 32'(t[10:5]);
    b = 32'(t[4:0]);
    return {a, 8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
  endfunction
  task automatic apply(input pix_t p);
    texture_enable_i = p.te; tex_base_i = p.base; tex_size_x_i = p.sx; tex_size_y_i = p.sy;
    u_i = p.u; v_i = p.v; pixel_x_i = p.x; pixel_y_i = p.y; pixel_z_i = p.z; a_i = p.a;
    color_i = p.color; colorkey_enable_i = p.cke; colorkey_i = p.key;
  endtask
  task automatic transact(input int id, input pix_t p, input int busy_n, input int ack_dly, input int wr_dly,
                          input logic [31:0] e_addr, input logic [31:0] e_color, input logic e_write);
    int req_first = -1, tack_at = -1, wr_first = -1, ack_i_at = -1, ack_edge = -1, hold = -1;
    int wr_rises = 0, ack_cnt = 0, unstable = 0, req_drop = 0, post_act = 0;
    logic prev_w = 0, tack_done = 0, fin = 0;
    logic [31:0] addr_seen = 0;
    logic [87:0] snap = 0;
    apply(p);
    write_i = 1'b1;
    wbm_busy_i = 1'b1;
    for (int k = 0; k < 400 && !fin; k++) begin
      @(posedge clk_i); #1;
      if (tex_ack_i) begin tex_ack_i = 1'b0; tack_done = 1'b1; end
      if (ack_i) ack_i = 1'b0;
      if (tex_request_o && req_first < 0) begin req_first = k; addr_seen = tex_addr_o; tack_at = k + ack_dly; end
      if (req_first >= 0 && !tack_done && !tex_request_o) req_drop++;
      if (k == tack_at) begin
        tex_ack_i = 1'b1;
        for (int l = 0; l < MDW / 16; l++) tex_data_i[l*16 +: 16] = mem16(tex_addr_o + 32'(2 * l));
      end
      if (write_o && !prev_w) begin
        wr_rises++;
        wr_first = k;
        snap = {color_o, pixel_x_o, pixel_y_o, pixel_z_o, a_o};
        ack_i_at = k + wr_dly;
      end
      if (write_o && snap != {color_o, pixel_x_o, pixel_y_o, pixel_z_o, a_o}) unstable++;
      if (k == ack_i_at) ack_i = 1'b1;
      if (ack_o) begin ack_cnt++; if (hold < 0) begin ack_edge = k; hold = k + 1; end end
      if (hold >= 0 && k > hold && (write_o || ack_o || tex_request_o)) post_act++;
      if (k == hold) write_i = 1'b0;
      if (hold >= 0 && k == hold + 4) fin = 1'b1;
      prev_w = write_o;
      wbm_busy_i = (k + 1 < 2 + busy_n);
    end
    write_i = 1'b0; tex_ack_i = 1'b0; ack_i = 1'b0; wbm_busy_i = 1'b0;
    chk($sformatf("t%0d finished", id), fin, 1);
    chk($sformatf("t%0d req_first", id), req_first, p.te ? 2 + busy_n : -1);
    if (p.te) begin
      chk($sformatf("t%0d tex_addr", id), addr_seen, e_addr);
      chk($sformatf("t%0d req_drop", id), req_drop, 0);
    end
    chk($sformatf("t%0d writes", id), wr_rises, e_write);
    if (e_write) begin
      chk($sformatf("t%0d color", id), snap[87:56], e_color);
      chk($sformatf("t%0d xyza", id), snap[55:0], {p.x, p.y, p.z, p.a});
      chk($sformatf("t%0d stable", id), unstable, 0);
      chk($sformatf("t%0d wr_lat", id), wr_first, p.te ? tack_at + 2 : 1);
    end
    chk($sformatf("t%0d ack_pulses", id), ack_cnt, 1);
    chk($sformatf("t%0d ack_lat", id), ack_edge, e_write ? ack_i_at + 1 : tack_at + 1);
    chk($sformatf("t%0d post_idle", id), post_act, 0);
  endtask
  initial begin
    pix_t p;
    logic [31:0] b, c;
    logic keyed, seen, act;
    tbl[0] = '{'{1'b0, 32'h0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd5, 16'd7, 16'd9, 8'h40, 32'h11223344, 1'b0, 32'h0},
               32'h0, 16'h0, 32'h0, 32'h11223344, 1'b1};
    tbl[1] = '{'{1'b1, 32'h1000, 16'd100, 16'd10, 16'd3, 16'd2, 16'd1, 16'd2, 16'd3, 8'h80, 32'hDEAD, 1'b0, 32'h0},
               32'h1196, 16'hF800, 32'h1180, 32'h80FF0000, 1'b1};
    tbl[2] = '{'{1'b1, 32'h2000, 16'd64, 16'd32, 16'd200, 16'd40, 16'd4, 16'd5, 16'd6, 8'hFF, 32'h0, 1'b0, 32'h0},
               32'h2FFE, 16'h07E0, 32'h2FE0, 32'hFF00FF00, 1'b1};
    tbl[3] = '{'{1'b1, 32'h3002, 16'd0, 16'd0, 16'd9, 16'd9, 16'd8, 16'd8, 16'd8, 8'h10, 32'h0, 1'b0, 32'h0},
               32'h3002, 16'h001F, 32'h3000, 32'h100000FF, 1'b1};
    tbl[4] = '{'{1'b1, 32'h4000, 16'd4, 16'd4, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 8'h22, 32'h0, 1'b1, 32'h00FFFFFF},
               32'h4000, 16'hFFFF, 32'h4000, 32'h22FFFFFF, !KEY_EN};
    tbl[5] = '{'{1'b1, 32'h5000, 16'd4, 16'd4, 16'd0, 16'd0, 16'd2, 16'd2, 16'd2, 8'h22, 32'h0, 1'b1, 32'hABFFFFF7},
               32'h5000, 16'hFFFE, 32'h5000, 32'h22FFFFF7, !KEY_EN};
    tbl[6] = '{'{1'b1, 32'h5000, 16'd4, 16'd4, 16'd0, 16'd0, 16'd3, 16'd3, 16'd3, 8'h22, 32'h0, 1'b0, 32'hABFFFFF7},
               32'h5000, 16'hFFFE, 32'h5000, 32'h22FFFFF7, 1'b1};
    tbl[7] = '{'{1'b1, 32'hFFFFFFF0, 16'd16, 16'd1, 16'd15, 16'd0, 16'd7, 16'd7, 16'd7, 8'h01, 32'h0, 1'b0, 32'h0},
               32'h0000000E, 16'h1234, 32'h0, 32'h011045A5, 1'b1};
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset outputs", |{ack_o, tex_request_o, tex_addr_o, pixel_x_o, pixel_y_o, pixel_z_o, a_o, color_o, write_o}, 0);
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      force_en = 1'b1; force_addr = tbl[i].f_addr; force_val = tbl[i].f_val;
      transact(i, tbl[i].p, 0, 1, 3, tbl[i].e_addr, tbl[i].e_color, tbl[i].e_write);
    end
    force_en = 1'b1; force_addr = tbl[1].f_addr; force_val = tbl[1].f_val;
    transact(20, tbl[1].p, 4, 5, 2, tbl[1].e_addr, tbl[1].e_color, 1'b1);
    force_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      p.te = ($urandom % 4) != 0;
      p.base = $urandom & 32'hFFFF_FFFE;
      p.sx = ($urandom % 8 == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      p.sy = ($urandom % 8 == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      p.u = 16'($urandom_range(0, 400)); p.v = 16'($urandom_range(0, 400));
      p.x = 16'($urandom); p.y = 16'($urandom); p.z = 16'($urandom); p.a = 8'($urandom);
      p.color = $urandom; p.cke = 1'($urandom); p.key = $urandom;
      b = m_byte(p);
      c = m_argb(p.a, mem16(b));
      if ($urandom % 2 == 1) p.key = {8'($urandom), c[23:0]};
      keyed = KEY_EN && p.te && p.cke && p.key[23:0] == c[23:0];
      transact(100 + i, p, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               b & ~32'(MDW / 8 - 1), p.te ? c : p.color, !keyed);
    end
    force_en = 1'b1; force_addr = tbl[1].f_addr; force_val = tbl[1].f_val;
    apply(tbl[1].p);
    write_i = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin @(posedge clk_i); #1; seen = tex_request_o; end
    chk("rst req_seen", seen, 1);
    rst_ni = 1'b0; write_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rst mid-fetch outputs", |{ack_o, tex_request_o, tex_addr_o, pixel_x_o, pixel_y_o, pixel_z_o, a_o, color_o, write_o}, 0);
    rst_ni = 1'b1; tex_ack_i = 1'b1; tex_data_i = {8{32'h1234_5678}};
    act = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_i); #1;
      tex_ack_i = 1'b0;
      act = act | write_o | ack_o | tex_request_o;
    end
    chk("late tex_ack ignored", act, 0);
    transact(30, tbl[1].p, 0, 2, 1, tbl[1].e_addr, tbl[1].e_color, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gfx_fragment_tex.md
Name: gfx_fragment_tex

Overview:
- Fragment stage directly downstream of the clip/z-cull stage.
- Accepts one surviving pixel per write/ack handshake.
- When texturing is enabled:
  - clamps (u,v) to the texture size;
  - fetches the 16bpp RGB565 texel through the wishbone reader;
  - expands the texel to 32-bit ARGB, using the pixel alpha as A;
  - optionally discards colour-keyed texels.
- Forwards the resulting pixel to the blender with the same write/ack protocol.

Parameters:
- point_width, 16, width of coordinate, u/v and z fields.
- MDW, 256, memory data bus width in bits. Must be a power of 2 and ≥ 32.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- texture_enable_i  in  1  1 = sample texture; 0 = pass color_i through
- tex_base_i  in  32  texture byte base address
- tex_size_x_i  in  point_width  texture width in texels
- tex_size_y_i  in  point_width  texture height in texels
- colorkey_enable_i  in  1  discard texels equal to colorkey_i
- colorkey_i  in  32  key value, compared against the expanded ARGB with A masked off
- pixel_x_i, pixel_y_i, pixel_z_i  in  point_width each  pixel from clip stage
- u_i, v_i  in  point_width each  texture coordinates
- a_i  in  8  pixel alpha
- color_i  in  32  flat/vertex colour
- write_i  in  1  pixel valid from clip stage (held high until ack_o)
- ack_o  out  1  one-cycle completion pulse to clip stage
- tex_request_o  out  1  read request to wishbone reader
- tex_addr_o  out  32  MDW-aligned byte address
- tex_ack_i  in  1  read data valid
- tex_data_i  in  MDW  read data
- wbm_busy_i  in  1  reader busy; request not raised while set
- pixel_x_o, pixel_y_o, pixel_z_o  out  point_width each  to blender
- a_o  out  8  to blender
- color_o  out  32  to blender
- write_o  out  1  pixel valid to blender
- ack_i  in  1  blender accepted pixel

Behaviour:
- Reset (rst_ni=0 at a clock edge): all outputs 0, state IDLE. Reset mid-fetch abandons the request; a late tex_ack_i is then ignored because the block is in IDLE.
- States are one-hot: IDLE, ADDR, FETCH, OUT, ACK.
- IDLE:
  - On write_i, latch all pixel inputs.
  - texture_enable_i=0: color_o<=color_i, go to OUT.
  - Otherwise go to ADDR.
- ADDR (1 cycle, registered multiply):
  - uc = min(u_i, tex_size_x_i-1); vc = min(v_i, tex_size_y_i-1).
  - A size of 0 is treated as 1, giving index 0.
  - byte = tex_base_i + (vc*tex_size_x_i + uc)*2, 32-bit, wraps modulo 2^32.
  - tex_addr_o = byte with the low log2(MDW/8) bits cleared.
  - Register lane = byte[log2(MDW/8)-1:1].
- FETCH:
  - tex_request_o <= tex_request_o | ~wbm_busy_i.
  - On tex_ack_i: tex_request_o<=0; texel = tex_data_i[lane*16 +: 16].
  - Expansion: argb = {a, r5,r5[4:2], g6,g6[5:4], b5,b5[4:2]}.
  - If keyed, go to ACK with write_o never raised; else color_o<=argb, go to OUT.
- OUT: write_o=1 and held until ack_i; on ack_i, write_o<=0 and go to ACK.
- ACK: ack_o=1 for exactly one cycle, then IDLE. write_i is ignored in ACK because the clip stage's write is still high that cycle.
- Latency, texture off: write_i sampled at edge 0 → write_o high after edge 1. After ack_i, ack_o follows 1 cycle later.
- Latency, texture on: tex_request_o is first high after edge 2 if the reader is not busy.
- Pixel outputs are stable for the whole time write_o=1.
- tex_ack_i outside FETCH is ignored.

Optional Feature:
- Macro: GFX_FRAG_COLORKEY_EN.
- Defined: colour-key discard as described above.
- Undefined: colorkey_enable_i and colorkey_i are ignored (ports kept), no comparator is built, and every fetched texel goes to OUT.

Decomposition:
- gfx_pkg gets:
  - frag_state_e, the one-hot state indices;
  - constant TEXEL_BPP=16;
  - function rgb565_to_argb(a,texel).
- One sub-module, gfx_texel_extract: lane mux plus expansion, combinational, parameterised by MDW.

Test Plan:
- Pass-through: texture off, color_i=32'h11223344, x=5,y=7, ack_i 3 cycles after write_o → color_o=11223344, x/y forwarded, ack_o single pulse one cycle after ack_i, no tex_request_o.
- Address/lane: base=32'h1000, size_x=100, u=3, v=2 → byte=0x1000+406=0x1196, tex_addr_o=0x1180, lane=11; texel F800 in that lane with a_i=80 → color_o=80FF0000.
- Clamp: size 64x32, u=200, v=40 → uc=63, vc=31, byte=base+(31*64+63)*2.
- Busy: wbm_busy_i high 4 cycles in FETCH → tex_request_o stays 0, then rises and holds until tex_ack_i.
- Colour key (macro on): key 00FFFFFF, texel FFFF → write_o never asserted, ack_o pulses once; macro off → pixel written.
- Back-to-back and reset: clip write held through ACK → only one pixel accepted per handshake; rst_ni=0 during FETCH → all outputs 0 next cycle, subsequent tex_ack_i ignored.
